// File: rtl/vfm_core_mailbox_pkg.sv
// Shared definitions for the vfm_core_mailbox message hub.
// Holds the index-width helper and default payload width.
package vfm_core_mailbox_pkg;

  localparam int DEF_DATA_W = 14;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/vfm_mailbox_fifo.sv
// Per-core inbox: synchronous FIFO with wrap pointers and explicit count.
// Head reads as zero while empty.
module vfm_mailbox_fifo
  import vfm_core_mailbox_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  localparam int PW = clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_cnt == CNT_W'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign count  = r_cnt;
  assign head   = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/vfm_core_mailbox.sv
// Any-to-any inter-core message hub: per-inbox round-robin
// arbitration in front of one FIFO inbox per core.
module vfm_core_mailbox
  import vfm_core_mailbox_pkg::*;
#(
  parameter int  NUM_CORES = 4,
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  DEPTH     = 4,
  localparam int ID_W      = clog2(NUM_CORES),
  localparam int CNT_W     = clog2(DEPTH) + 1
) (
  input  logic                        Clock_pin,
  input  logic                        Resetn_pin,
  input  logic [NUM_CORES-1:0]        tx_valid,
  input  logic [NUM_CORES*ID_W-1:0]   tx_dest,
  input  logic [NUM_CORES*DATA_W-1:0] tx_data,
  output logic [NUM_CORES-1:0]        tx_ready,
  output logic [NUM_CORES-1:0]        rx_valid,
  output logic [NUM_CORES*ID_W-1:0]   rx_src,
  output logic [NUM_CORES*DATA_W-1:0] rx_data,
  input  logic [NUM_CORES-1:0]        rx_pop,
  output logic [NUM_CORES*CNT_W-1:0]  rx_count,
  output logic [NUM_CORES-1:0]        err_bad_dest
);

  localparam int FW = ID_W + DATA_W;

  logic [ID_W-1:0]      r_last [NUM_CORES];
  logic [NUM_CORES-1:0] r_err;

  logic [ID_W-1:0]      w_dst  [NUM_CORES];
  logic [NUM_CORES-1:0] w_bad;
  logic [NUM_CORES-1:0] w_req  [NUM_CORES];
  logic [ID_W-1:0]      w_win  [NUM_CORES];
  logic [FW-1:0]        w_din  [NUM_CORES];
  logic [NUM_CORES-1:0] w_hit;
  logic [NUM_CORES-1:0] w_acc;
  logic [NUM_CORES-1:0] w_full;
  logic [NUM_CORES-1:0] w_rdy;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_dst[i] = tx_dest[slice_lo(i, ID_W) +: ID_W];
      w_bad[i] = (int'(w_dst[i]) >= NUM_CORES);
    end
    for (int d = 0; d < NUM_CORES; d++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        w_req[d][i] = tx_valid[i] && !w_bad[i] &&
                      (w_dst[i] == ID_W'(d));
      end
    end
  end

  // Search starts one past the last accepted sender.
  always_comb begin
    int idx;
    idx = 0;
    for (int d = 0; d < NUM_CORES; d++) begin
      w_hit[d] = 1'b0;
      w_win[d] = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
        idx = (int'(r_last[d]) + k) % NUM_CORES;
        if (!w_hit[d] && w_req[d][idx]) begin
          w_hit[d] = 1'b1;
          w_win[d] = ID_W'(idx);
        end
      end
      w_acc[d] = w_hit[d] && !w_full[d];
      w_din[d] = {w_win[d],
                  tx_data[slice_lo(int'(w_win[d]), DATA_W) +: DATA_W]};
    end
  end

  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (tx_valid[i] && w_bad[i]) w_rdy[i] = 1'b1;
    end
    for (int d = 0; d < NUM_CORES; d++) begin
      if (w_acc[d]) w_rdy[w_win[d]] = 1'b1;
    end
  end

  assign tx_ready     = Resetn_pin ? w_rdy : '0;
  assign err_bad_dest = r_err;

  always_ff @(posedge Clock_pin) begin
    if (!Resetn_pin) begin
      for (int d = 0; d < NUM_CORES; d++) begin
        r_last[d] <= ID_W'(NUM_CORES - 1);
      end
      r_err <= '0;
    end else begin
      for (int d = 0; d < NUM_CORES; d++) begin
        if (w_acc[d]) r_last[d] <= w_win[d];
      end
      r_err <= r_err | (tx_valid & w_bad);
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_inbox
    logic [FW-1:0] w_head;
    logic          w_empty;

    vfm_mailbox_fifo #(
      .W     (FW),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk   (Clock_pin),
      .rst_n (Resetn_pin),
      .push  (w_acc[g]),
      .pop   (rx_pop[g]),
      .din   (w_din[g]),
      .full  (w_full[g]),
      .empty (w_empty),
      .count (rx_count[g*CNT_W +: CNT_W]),
      .head  (w_head)
    );

    assign rx_valid[g]                = !w_empty;
    assign rx_src[g*ID_W +: ID_W]     = w_head[FW-1 -: ID_W];
    assign rx_data[g*DATA_W +: DATA_W] = w_head[DATA_W-1:0];
  end

endmodule

// File: tb/tb_vfm_core_mailbox.sv
// Scoreboard bench for vfm_core_mailbox (3 cores, depth 4):
// directed scenarios then randomized traffic against a queue model.
module tb_vfm_core_mailbox;

  localparam int N   = 3;
  localparam int DW  = 14;
  localparam int DEP = 4;
  localparam int IDW = 2;
  localparam int CW  = 3;

  logic             clk;
  logic             rstn;
  logic [N-1:0]     tx_valid;
  logic [N*IDW-1:0] tx_dest;
  logic [N*DW-1:0]  tx_data;
  logic [N-1:0]     tx_ready;
  logic [N-1:0]     rx_valid;
  logic [N*IDW-1:0] rx_src;
  logic [N*DW-1:0]  rx_data;
  logic [N-1:0]     rx_pop;
  logic [N*CW-1:0]  rx_count;
  logic [N-1:0]     err_bad_dest;

  vfm_core_mailbox #(.NUM_CORES(N), .DATA_W(DW), .DEPTH(DEP)) dut (
    .Clock_pin    (clk),
    .Resetn_pin   (rstn),
    .tx_valid     (tx_valid),
    .tx_dest      (tx_dest),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_src       (rx_src),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .rx_count     (rx_count),
    .err_bad_dest (err_bad_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  int sb [N][$];
  int occ [N];
  int last [N];
  bit merr [N];

  // stimulus for the next cycle
  bit v_rst;
  bit v_valid [N];
  int v_dest  [N];
  int v_data  [N];
  bit v_pop   [N];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      v_valid[i] = 0;
      v_dest[i]  = 0;
      v_data[i]  = 0;
      v_pop[i]   = 0;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < N; d++) begin
      sb[d].delete();
      occ[d]  = 0;
      last[d] = N - 1;
      merr[d] = 0;
    end
  endtask

  task automatic check_and_update();
    logic [N-1:0] er;
    bit psh [N];
    er = '0;
    if (v_rst) begin
      chk("ready_in_reset", 32'(tx_ready), 0);
      model_clear();
      return;
    end
    for (int d = 0; d < N; d++) begin
      chk($sformatf("rx_valid%0d", d), 32'(rx_valid[d]), 32'(occ[d] > 0));
      chk($sformatf("rx_count%0d", d), 32'(rx_count[d*CW +: CW]),
          32'(occ[d]));
      if (occ[d] == 0) begin
        chk($sformatf("empty_src%0d", d), 32'(rx_src[d*IDW +: IDW]), 0);
        chk($sformatf("empty_data%0d", d), 32'(rx_data[d*DW +: DW]), 0);
      end
      chk($sformatf("err%0d", d), 32'(err_bad_dest[d]), 32'(merr[d]));
    end
    for (int d = 0; d < N; d++) begin
      psh[d] = 0;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last[d] + k) % N;
        if (v_valid[i] && v_dest[i] == d) begin
          if (occ[d] < DEP) begin
            er[i]  = 1'b1;
            psh[d] = 1;
            sb[d].push_back(i * 65536 + v_data[i]);
            last[d] = i;
          end
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (v_valid[i] && v_dest[i] >= N) begin
        er[i]   = 1'b1;
        merr[i] = 1;
      end
    end
    chk("tx_ready", 32'(tx_ready), 32'(er));
    for (int d = 0; d < N; d++) begin
      occ[d] = occ[d] + int'(psh[d]) - int'(v_pop[d] && occ[d] > 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rstn = !v_rst;
    for (int i = 0; i < N; i++) begin
      tx_valid[i]            = v_valid[i];
      tx_dest[i*IDW +: IDW]  = IDW'(v_dest[i]);
      tx_data[i*DW +: DW]    = DW'(v_data[i]);
      rx_pop[i]              = v_pop[i];
    end
    @(negedge clk);
    check_and_update();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < N; i++) v_pop[i] = 1;
    repeat (DEP + 1) step();
    idle();
  endtask

  // monitor: compares every presented inbox head with the scoreboard
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      for (int d = 0; d < N; d++) begin
        if (rx_valid[d] === 1'b1) begin
          if (sb[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL head%0d actual=present required=empty", d);
          end else begin
            chk($sformatf("head_src%0d", d), 32'(rx_src[d*IDW +: IDW]),
                32'(sb[d][0] / 65536));
            chk($sformatf("head_data%0d", d), 32'(rx_data[d*DW +: DW]),
                32'(sb[d][0] % 65536));
            if (rx_pop[d] === 1'b1) void'(sb[d].pop_front());
          end
        end
      end
    end
  end

  initial begin
    int k;
    rstn = 0;
    tx_valid = '0;
    tx_dest = '0;
    tx_data = '0;
    rx_pop = '0;
    model_clear();
    idle();
    v_rst = 1;
    repeat (3) step();
    v_rst = 0;

    // single send 2 -> 0, then pop
    v_valid[2] = 1; v_dest[2] = 0; v_data[2] = 'h1ABC;
    step();
    idle(); step();
    v_pop[0] = 1; step();
    idle(); step();

    // contention: everyone targets inbox 0
    for (int c = 0; c < 10; c++) begin
      idle();
      for (int i = 0; i < N; i++) begin
        v_valid[i] = 1; v_dest[i] = 0; v_data[i] = 'h200 + c * 4 + i;
      end
      v_pop[0] = (c >= 2);
      step();
    end
    drain();

    // fill inbox 2 from core 1 with no pops, then release one slot
    k = 0;
    for (int c = 0; c < 9; c++) begin
      idle();
      v_valid[1] = 1; v_dest[1] = 2; v_data[1] = 'h100 + k;
      v_pop[2] = (c == 6);
      step();
      if (tx_ready[1] === 1'b1) k++;
    end
    drain();

    // pop on empty inboxes
    for (int i = 0; i < N; i++) v_pop[i] = 1;
    repeat (2) step();

    // push and pop together at count 2
    idle();
    v_valid[0] = 1; v_dest[0] = 1; v_data[0] = 'h11;
    step();
    v_data[0] = 'h22; step();
    v_data[0] = 'h33; v_pop[1] = 1; step();
    idle(); step();
    drain();

    // bad destination from core 0, sticky afterwards
    v_valid[0] = 1; v_dest[0] = 3; v_data[0] = 'h3FFF;
    step();
    idle();
    repeat (3) step();

    // randomized traffic
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        v_valid[i] = $urandom_range(0, 2) != 0;
        v_dest[i]  = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, N - 1);
        v_data[i]  = $urandom_range(0, (1 << DW) - 1);
        v_pop[i]   = $urandom_range(0, 1);
      end
      step();
    end
    drain();

    // reset while inbox 1 holds 3 entries and a send is in flight
    for (int c = 0; c < 3; c++) begin
      idle();
      v_valid[2] = 1; v_dest[2] = 1; v_data[2] = 'h50 + c;
      step();
    end
    v_valid[0] = 1; v_dest[0] = 1; v_data[0] = 'h77;
    v_rst = 1;
    step();
    v_rst = 0;
    idle(); step();
    for (int c = 0; c < 6; c++) begin
      idle();
      for (int i = 0; i < N; i++) begin
        v_valid[i] = 1; v_dest[i] = 0; v_data[i] = 'h300 + c * 4 + i;
      end
      v_pop[0] = 1;
      step();
    end
    drain();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
